// File: rtl/fact_sched.sv
// fact_sched: round-robin scheduler that shares one iterative factorial
// engine between NREQ requesters.
// A job is accepted in IDLE. MUL performs one multiply per cycle.
// DONE holds the result on a shared response bus until the granted
// requester takes it.
module fact_sched #(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int NMAX = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_n,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [7:0]      NMAX8   = 8'(NMAX);
    localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state;
    logic [W-1:0]    acc;
    logic [7:0]      cnt;
    logic [1:0]      last;
    logic [1:0]      gid;
    logic            ovf;

    logic            found;
    logic [1:0]      win;
    logic [7:0]      sel_n;
    logic [NREQ-1:0] win_hot;
    logic [NREQ-1:0] gid_hot;
    logic            rsp_ack;
    logic [W-1:0]    cnt_wide;

    // Round-robin pick: first valid requester after the last one served, wrapping
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (((int'(last) + 1 + k) % NREQ) == i)) begin
                    found = 1'b1;
                    win   = 2'(i);
                end
            end
        end
    end

    // Operand of the current winner, taken from its byte lane
    always_comb begin
        sel_n = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 2'(i)) begin
                sel_n = req_n[8*i +: 8];
            end
        end
    end

    assign win_hot  = ONE_HOT << win;
    assign gid_hot  = ONE_HOT << gid;
    assign rsp_ack  = |(rsp_valid & rsp_ready & gid_hot);
    assign cnt_wide = W'(cnt);

    assign req_ready = (state == IDLE && found) ? win_hot : '0;
    assign rsp_data  = acc;
    assign rsp_ovf   = ovf;
    assign busy      = (state != IDLE);
    assign grant_id  = gid;

    // Job sequencer: accept, multiply down the counter, then hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= 8'd0;
            last      <= 2'(NREQ - 1);
            gid       <= 2'd0;
            ovf       <= 1'b0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gid <= win;
                        cnt <= sel_n;
                        if (sel_n > NMAX8) begin
                            ovf   <= 1'b1;
                            acc   <= '1;
                            state <= DONE;
                        end else begin
                            ovf   <= 1'b0;
                            acc   <= W'(1);
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (cnt <= 8'd1) begin
                        state <= DONE;
                    end else begin
                        acc <= acc * cnt_wide;
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    if (rsp_ack) begin
                        rsp_valid <= '0;
                        last      <= gid;
                        state     <= IDLE;
                    end else begin
                        rsp_valid <= gid_hot;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_sched.sv
// tb_fact_sched: drives fact_sched with directed and random jobs.
// The results are compared against a factorial/round-robin reference model.
module tb_fact_sched;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int NMAX = 12;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_n;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_ovf;
    logic              busy;
    logic [1:0]        grant_id;

    int checkCount;
    int passCount;
    int lastModel;

    fact_sched #(.NREQ(NREQ), .W(W), .NMAX(NMAX)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_n(req_n),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf),
        .busy(busy),
        .grant_id(grant_id)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference factorial, saturating to all ones above NMAX
    function automatic logic [31:0] refResult(input int n);
        longint p;
        if (n > NMAX) return 32'hFFFF_FFFF;
        p = 1;
        for (int i = 2; i <= n; i++) p = p * i;
        return p[31:0];
    endfunction

    // Edges from accept to rsp_valid rising
    function automatic int refLatency(input int n);
        if (n > NMAX) return 1;
        return ((n < 1) ? 1 : n) + 1;
    endfunction

    // Round-robin winner from the requester after lastModel
    function automatic int refWinner(input logic [NREQ-1:0] mask, input int lastServed);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (lastServed + 1 + k) % NREQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Present one job, wait for its result, check it, and hand it back
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int n0, input int n1,
                                 input bit holdValid, input int readyDelay);
        int w, nw, waits, k;
        logic [NREQ-1:0] expHot;
        logic [NREQ-1:0] heldValid;
        logic [W-1:0]    heldData;
        bit stable;
        req_n[7:0]  = 8'(n0);
        req_n[15:8] = 8'(n1);
        req_valid   = mask;
        rsp_ready   = (readyDelay == 0) ? '1 : '0;
        w      = refWinner(mask, lastModel);
        nw     = (w == 0) ? n0 : n1;
        expHot = NREQ'(1) << w;
        #1;
        waits = 0;
        while (req_ready == '0 && waits < 20) begin
            tick();
            waits++;
        end
        checkOutput("acceptWait", 32'(waits), 32'd0);
        checkOutput("reqReady", 32'(req_ready), 32'(expHot));
        tick();
        if (!holdValid) req_valid = '0;
        k = 0;
        while (rsp_valid == '0 && k < 40) begin
            tick();
            k++;
        end
        checkOutput("latency", 32'(k), 32'(refLatency(nw)));
        checkOutput("rspValid", 32'(rsp_valid), 32'(expHot));
        checkOutput("rspData", rsp_data, refResult(nw));
        checkOutput("rspOvf", 32'(rsp_ovf), 32'(nw > NMAX));
        checkOutput("grantId", 32'(grant_id), 32'(w));
        checkOutput("busy", 32'(busy), 32'd1);
        if (readyDelay > 0) begin
            heldValid = rsp_valid;
            heldData  = rsp_data;
            stable    = 1'b1;
            for (int c = 0; c < readyDelay; c++) begin
                tick();
                if (rsp_valid !== heldValid || rsp_data !== heldData) stable = 1'b0;
            end
            checkOutput("holdStable", 32'(stable), 32'd1);
            rsp_ready = '1;
        end
        tick();
        checkOutput("rspFall", 32'(rsp_valid), 32'd0);
        rsp_ready = '0;
        lastModel = w;
    endtask

    // Test sequence: directed cases from the plan, then randomized jobs
    initial begin
        checkCount = 0;
        passCount  = 0;
        lastModel  = NREQ - 1;
        rst        = 1'b1;
        req_valid  = '0;
        req_n      = '0;
        rsp_ready  = '0;
        #3;
        checkOutput("rstReqReady", 32'(req_ready), 32'd0);
        checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rstRspData", rsp_data, 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstGrant", 32'(grant_id), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        applyStimulus(2'b01, 5, 0, 1'b0, 0);
        applyStimulus(2'b01, 0, 0, 1'b0, 0);
        applyStimulus(2'b01, 1, 0, 1'b0, 0);
        applyStimulus(2'b01, 12, 0, 1'b0, 0);
        applyStimulus(2'b10, 0, 13, 1'b0, 0);

        // Both requesters held valid continuously: grants must alternate
        for (int j = 0; j < 4; j++) applyStimulus(2'b11, 3, 4, 1'b1, 0);

        // Long stall in DONE with the other requester waiting
        applyStimulus(2'b11, 6, 2, 1'b1, 10);
        applyStimulus(2'b11, 6, 2, 1'b0, 0);

        // Asynchronous reset in the middle of a multiply sequence
        req_n[7:0] = 8'd10;
        req_valid  = 2'b01;
        rsp_ready  = '1;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("midRstRspData", rsp_data, 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstGrant", 32'(grant_id), 32'd0);
        checkOutput("midRstOvf", 32'(rsp_ovf), 32'd0);
        checkOutput("midRstReqReady", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        lastModel = NREQ - 1;
        tick();
        applyStimulus(2'b11, 10, 3, 1'b0, 0);

        // Randomized requester masks, operands and response stalls
        for (int j = 0; j < 14; j++) begin
            applyStimulus(2'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), 1'b0, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
